// File: rtl/i2s_slave_tx.sv
// i2s_slave_tx: I2S target transmitter, sck/ws from an external master, samples pushed via ready/valid FIFO.
// Define I2S_SLAVE_TX_REPEAT_EN to retransmit the last popped pair on underrun instead of zeros.
module i2s_slave_tx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     ck,
  input  logic                     reset,
  input  logic                     sck,
  input  logic                     ws,
  output logic                     sd,
  input  logic [2*WIDTH-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_strobe,
  output logic                     underrun,
  input  logic                     underrun_clr
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {SYNC, IDLE, RUN} state_t;
  state_t state_q;
  logic sck_s1_q, sck_s2_q, sck_s3_q, ws_s1_q, ws_s2_q;
  logic ws_r_q, ws_last_q, sd_q, fs_q, underrun_q;
  logic [WIDTH-1:0] sh_q, hold_q;
  logic [5:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] fill;
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] count_q;
  logic sck_rise, sck_fall, slot_start, left_go, right_go, empty, push, pop;
  assign sck_rise = sck_s2_q & ~sck_s3_q;
  assign sck_fall = ~sck_s2_q & sck_s3_q;
  assign slot_start = sck_fall && (ws_r_q != ws_last_q);
  assign left_go = slot_start && !ws_r_q && state_q != SYNC;
  assign right_go = slot_start && ws_r_q && state_q == RUN;
  assign empty = count_q == '0;
  assign in_ready = count_q != LW'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = left_go && !empty;
  assign cnt_d = cnt_q == 6'(WIDTH) ? cnt_q : cnt_q + 6'd1;
  assign sd = sd_q;
  assign level = count_q;
  assign frame_strobe = fs_q;
  assign underrun = underrun_q;
`ifdef I2S_SLAVE_TX_REPEAT_EN
  logic [2*WIDTH-1:0] last_q;
  assign fill = empty ? last_q : mem_q[rp_q];
  always_ff @(posedge ck)
    if (reset) last_q <= '0;
    else if (pop) last_q <= mem_q[rp_q];
`else
  assign fill = empty ? '0 : mem_q[rp_q];
`endif
  always_ff @(posedge ck)
    if (reset) begin
      {sck_s1_q, sck_s2_q, sck_s3_q, ws_s1_q, ws_s2_q} <= '0;
    end else begin
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      ws_s1_q <= ws;
      ws_s2_q <= ws_s1_q;
    end
  // A left start seen from IDLE already loads the first word, so output begins on a whole frame.
  always_ff @(posedge ck)
    if (reset) begin
      state_q <= SYNC;
      ws_r_q <= 1'b0;
      ws_last_q <= 1'b0;
      sh_q <= '0;
      hold_q <= '0;
      cnt_q <= 6'(WIDTH);
      sd_q <= 1'b0;
      fs_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      fs_q <= pop;
      underrun_q <= (left_go && empty && state_q == RUN) || (underrun_q && !underrun_clr);
      if (sck_rise) ws_r_q <= ws_s2_q;
      if (sck_fall) ws_last_q <= ws_r_q;
      if (state_q == SYNC && sck_fall) state_q <= IDLE;
      if (left_go) begin
        state_q <= RUN;
        sh_q <= fill[2*WIDTH-1:WIDTH];
        hold_q <= fill[WIDTH-1:0];
        cnt_q <= '0;
        sd_q <= fill[2*WIDTH-1];
      end else if (right_go) begin
        sh_q <= hold_q;
        cnt_q <= '0;
        sd_q <= hold_q[WIDTH-1];
      end else if (sck_fall && state_q == RUN) begin
        sh_q <= sh_q << 1;
        cnt_q <= cnt_d;
        sd_q <= (cnt_d < 6'(WIDTH)) && sh_q[WIDTH-2];
      end
    end
  always_ff @(posedge ck)
    if (push) mem_q[wp_q] <= in_data;
  always_ff @(posedge ck)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wp_q <= wp_q == AW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
      if (pop) rp_q <= rp_q == AW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
      count_q <= count_q + LW'(push) - LW'(pop);
    end
endmodule

// File: tb/tb_i2s_slave_tx.sv
// tb_i2s_slave_tx: directed bench; acts as I2S master (sck = ck/16, 32-bit slots) and decodes sd.
module tb_i2s_slave_tx;
  logic ck = 1'b0, reset = 1'b1, sck = 1'b1, ws = 1'b1;
  logic sd, in_valid = 1'b0, in_ready, frame_strobe, underrun, underrun_clr = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0] level;
  logic [63:0] rx = '0;
  logic s;
  logic [31:0] ur_pair;
  int checks = 0, failures = 0, fs_cnt = 0;

  i2s_slave_tx #(.WIDTH(16), .DEPTH(4)) dut (
    .ck(ck), .reset(reset), .sck(sck), .ws(ws), .sd(sd),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .level(level),
    .frame_strobe(frame_strobe), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 ck = ~ck;
  always @(negedge ck) if (frame_strobe) fs_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, output logic smp);
    sck = 1'b0; ws = w; #80;
    sck = 1'b1; smp = sd; #80;
  endtask

  // 64 sck cycles, ws low for the first 32; rx[63-c] holds sd sampled at the rising edge of cycle c.
  task automatic frame(input int rc);
    for (int c = 0; c < 64; c++) begin
      sck = 1'b0; ws = (c >= 32);
      if (c == rc) begin
        @(negedge ck) reset = 1'b1;
        @(negedge ck);
        chk("reset_sd", {63'd0, sd}, 64'd0);
        chk("reset_level", {61'd0, level}, 64'd0);
        reset = 1'b0;
        #40;
      end else #80;
      sck = 1'b1; rx = {rx[62:0], sd}; #80;
    end
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge ck) in_data = d; in_valid = 1'b1;
    @(negedge ck) in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge ck);
    reset = 1'b0;
    @(negedge ck);
    chk("rst_sd", {63'd0, sd}, 64'd0);
    chk("rst_level", {61'd0, level}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_underrun", {63'd0, underrun}, 64'd0);
    chk("rst_strobe", {63'd0, frame_strobe}, 64'd0);
    // basic frame
    push(32'hA5C3_0F0F);
    chk("t1_level_pushed", {61'd0, level}, 64'd1);
    cyc(1'b1, s); cyc(1'b1, s);
    frame(-1);
    chk("t1_pre_msb", {63'd0, rx[63]}, 64'd0);
    chk("t1_msb", {63'd0, rx[62]}, 64'd1);
    chk("t1_left", {32'd0, rx[62:31]}, {32'd0, 32'hA5C3_0000});
    chk("t1_right", {33'd0, rx[30:0]}, {33'd0, 16'h0F0F, 15'h0});
    chk("t1_strobes", 64'(fs_cnt), 64'd1);
    chk("t1_level", {61'd0, level}, 64'd0);
    chk("t1_underrun", {63'd0, underrun}, 64'd0);
    // fill FIFO with master stopped, then a held 5th push
    for (int i = 1; i <= 4; i++) push({16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    chk("t3_level_full", {61'd0, level}, 64'd4);
    chk("t3_ready_full", {63'd0, in_ready}, 64'd0);
    @(negedge ck) in_data = 32'h1005_2005; in_valid = 1'b1;
    frame(-1);
    @(negedge ck) in_valid = 1'b0;
    chk("t3_level_refill", {61'd0, level}, 64'd4);
    chk("t3_ready_refill", {63'd0, in_ready}, 64'd0);
    chk("t3_left_1", {32'd0, rx[62:31]}, {32'd0, 32'h1001_0000});
    chk("t3_right_1", {33'd0, rx[30:0]}, {33'd0, 16'h2001, 15'h0});
    for (int i = 2; i <= 5; i++) begin
      frame(-1);
      chk("t3_left_n", {32'd0, rx[62:31]}, {32'd0, 16'h1000 + 16'(i), 16'h0});
      chk("t3_right_n", {33'd0, rx[30:0]}, {33'd0, 16'h2000 + 16'(i), 15'h0});
    end
    chk("t3_strobes", 64'(fs_cnt), 64'd6);
    chk("t3_level_drained", {61'd0, level}, 64'd0);
    // underrun
`ifdef I2S_SLAVE_TX_REPEAT_EN
    ur_pair = 32'h1005_2005;
`else
    ur_pair = 32'h0;
`endif
    frame(-1);
    chk("t4_left", {32'd0, rx[62:31]}, {32'd0, ur_pair[31:16], 16'h0});
    chk("t4_right", {33'd0, rx[30:0]}, {33'd0, ur_pair[15:0], 15'h0});
    chk("t4_underrun", {63'd0, underrun}, 64'd1);
    chk("t4_strobes", 64'(fs_cnt), 64'd6);
    frame(-1);
    chk("t4_underrun_sticky", {63'd0, underrun}, 64'd1);
    @(negedge ck) underrun_clr = 1'b1;
    @(negedge ck) underrun_clr = 1'b0;
    chk("t4_underrun_clr", {63'd0, underrun}, 64'd0);
    // reset mid right slot
    push(32'h1111_2222);
    frame(40);
    chk("t5_left_before_reset", {32'd0, rx[62:31]}, {32'd0, 32'h1111_0000});
    chk("t5_quiet_after_reset", {40'd0, rx[23:0]}, 64'd0);
    chk("t5_underrun", {63'd0, underrun}, 64'd0);
    push(32'hC0DE_BEEF);
    chk("t5_level_pushed", {61'd0, level}, 64'd1);
    frame(-1);
    chk("t5_pre_msb", {63'd0, rx[63]}, 64'd0);
    chk("t5_left", {32'd0, rx[62:31]}, {32'd0, 32'hC0DE_0000});
    chk("t5_right", {33'd0, rx[30:0]}, {33'd0, 16'hBEEF, 15'h0});
    chk("t5_strobes", 64'(fs_cnt), 64'd8);
    chk("t5_level", {61'd0, level}, 64'd0);
    // starve after a known pair
    push(32'h1234_5678);
    frame(-1);
    chk("t6_left", {32'd0, rx[62:31]}, {32'd0, 32'h1234_0000});
    chk("t6_right", {33'd0, rx[30:0]}, {33'd0, 16'h5678, 15'h0});
`ifdef I2S_SLAVE_TX_REPEAT_EN
    ur_pair = 32'h1234_5678;
`else
    ur_pair = 32'h0;
`endif
    frame(-1);
    chk("t6_starve_left", {32'd0, rx[62:31]}, {32'd0, ur_pair[31:16], 16'h0});
    chk("t6_starve_right", {33'd0, rx[30:0]}, {33'd0, ur_pair[15:0], 15'h0});
    chk("t6_underrun", {63'd0, underrun}, 64'd1);
    chk("t6_strobes", 64'(fs_cnt), 64'd9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_slave_tx.md
Name: i2s_slave_tx

Overview:
- I2S target-side transmitter: the far end of the engine's I2S link, i.e. what a microphone or codec looks like to the engine's clock-master receivers.
- sck and ws are driven by an external master; this block shifts stereo samples out on sd.
- Samples arrive through a ready/valid push port into a small FIFO.
- Used as a bench/loopback mic emulator and for board-to-board audio links.

Parameters:
- WIDTH, 16, bits per channel sample, MSB first; valid range 8..32.
- DEPTH, 4, FIFO depth in stereo pairs; must be a power of 2.

Ports:
- ck  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- sck  in  1  I2S bit clock from master (asynchronous to ck)
- ws  in  1  I2S word select from master; 0 = left, 1 = right
- sd  out  1  I2S serial data
- in_data  in  2*WIDTH  stereo pair, {left, right}
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept a pair
- level  out  $clog2(DEPTH)+1  FIFO occupancy in pairs
- frame_strobe  out  1  one-ck pulse when a pair is popped at left-slot start
- underrun  out  1  sticky: a left-slot start found the FIFO empty
- underrun_clr  in  1  clears underrun

Behaviour:
- Clocking:
  - sck and ws pass through 2-FF synchronisers into ck.
  - Edges of synced sck are detected with one further register.
  - Requires ck >= 8x sck; the engine divider of 16 meets this.
- Slot tracking:
  - ws_r captures synced ws on each sck rising edge.
  - On each sck falling edge: slot_start = (ws_r != ws_last); then ws_last <= ws_r.
  - This yields the standard one-bit delay: MSB is driven on the first falling edge after the master changes ws.
- State machine (states SYNC, IDLE, RUN):
  - SYNC: entered on reset. Waits for the first sck falling edge, captures ws_last without loading, then goes to IDLE.
  - IDLE: sd=0. Goes to RUN on a slot_start with ws_r=0 (left start).
  - RUN: on a left start, pops the FIFO, loads the left half into the shifter and holds the right half. On a right start, loads the held right half. On every other falling edge, shifts left.
- Bit counter:
  - sd = shifter MSB while bit count < WIDTH, else 0.
  - The counter saturates, so slots of any length up to 32 bits work.
- sd updates exactly 1 ck after the detected falling edge; it is stable at the next rising sck.
- FIFO:
  - in_ready = !full, combinational from the registered count.
  - A push occurs when in_valid && in_ready.
  - Simultaneous push and pop: both take effect and level is unchanged.
  - No bypass: a pop when empty is an underrun even if a push happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- Underrun:
  - Left start in RUN with FIFO empty: loads 0 for both channels, sets underrun, no frame_strobe.
  - underrun_clr clears the flag. A same-cycle set has priority over clear.
- Reset mid-operation:
  - FIFO emptied, level=0, sd=0, underrun=0, frame_strobe=0, state=SYNC.
  - Output restarts only at the next left start; no partial word is ever emitted.
- Reset values: sd=0, in_ready=1 (after the reset cycle), level=0, frame_strobe=0, underrun=0.

Optional Feature:
- I2S_SLAVE_TX_REPEAT_EN defined:
  - On underrun, the last successfully popped pair is retransmitted instead of zeros. underrun is still set.
  - The last pair resets to 0.
- Undefined: underrun frames transmit zeros.

Test Plan:
- Push {16'hA5C3, 16'h0F0F}, master sck = ck/16, 32-bit slots -> receiver decodes left=A5C3, right=0F0F; frame_strobe pulses once; level 1->0.
- Bit alignment -> left MSB (1) on sd starting at the 1st sck falling edge after ws 1->0 and held through the following rising edge; bits 16..31 of each slot are 0.
- Push 4 pairs with the master stopped -> level=4 and in_ready=0. A 5th push is held until the next left start pops, then accepted in the same or next cycle; level returns to 4.
- FIFO empty at left start -> sd 0 for the whole frame, underrun=1 and stays 1 over later frames. One underrun_clr cycle -> underrun=0.
- Reset asserted mid right slot:
  - Next cycle: sd=0, level=0.
  - Push during the remainder of the frame -> the first frame after the next left start carries that pair.
  - No partial word appears.
- With I2S_SLAVE_TX_REPEAT_EN: send {1234, 5678}, then starve -> the next frame repeats 1234/5678 and underrun=1. Without the macro, that frame is 0/0.
